// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, the S-box and byte helpers,
// the legal parameter triples with their elaboration check, and the
// FIPS-197 known-answer vectors.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic bit legal_params(input int n, input int nk, input int nr);
        return (n == 128 && nk == 4 && nr == 10) ||
               (n == 192 && nk == 6 && nr == 12) ||
               (n == 256 && nk == 8 && nr == 14);
    endfunction

    localparam logic [127:0] KAT_B_IN     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KAT_B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_B_OUT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KAT_C_IN     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_C128_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_C128_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] KAT_C192_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] KAT_C192_OUT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KAT_C256_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_C256_OUT = 128'h8ea2b7ca516745bfeafc49904b496089;

endpackage

// File: rtl/addRoundKey.sv
// XOR of a 128-bit state with a round key.
// Ports: in (state), key (round key), out (in ^ key).
module addRoundKey (
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out
);
    assign out = in ^ key;
endmodule

// File: rtl/aes_round_step.sv
// Combinational single-round transform for the iterative core.
// Ports: i_state (current state), i_round_key (round key for i_round),
//        i_round (round index 0..Nr), o_state (state after this round).
// Round 0 is the initial key whitening, round Nr omits mixColumns.
module aes_round_step #(
    parameter int Nr = 10,
    parameter int RW = $clog2(Nr+1)
) (
    input  logic [127:0]  i_state,
    input  logic [127:0]  i_round_key,
    input  logic [RW-1:0] i_round,
    output logic [127:0]  o_state
);
    localparam logic [RW-1:0] LAST_ROUND = RW'(Nr);

    logic [127:0] w_first, w_mid, w_sub, w_shift, w_last;

    addRoundKey  u_first (.in(i_state), .key(i_round_key), .out(w_first));
    encryptRound u_mid   (.in(i_state), .key(i_round_key), .out(w_mid));
    subBytes     u_sub   (.in(i_state), .out(w_sub));
    shiftRows    u_shift (.in(w_sub),   .out(w_shift));
    addRoundKey  u_last  (.in(w_shift), .key(i_round_key), .out(w_last));

    always_comb begin
        if (i_round == '0) begin
            o_state = w_first;
        end else if (i_round == LAST_ROUND) begin
            o_state = w_last;
        end else begin
            o_state = w_mid;
        end
    end
endmodule

// File: rtl/encryptRound.sv
// One full middle round: subBytes, shiftRows, mixColumns, addRoundKey.
// Ports: in (state), key (round key), out (next state).
module encryptRound (
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out
);
    logic [127:0] w_sub, w_shift, w_mix;

    subBytes    u_sub   (.in(in),      .out(w_sub));
    shiftRows   u_shift (.in(w_sub),   .out(w_shift));
    mixColumns  u_mix   (.in(w_shift), .out(w_mix));
    addRoundKey u_ark   (.in(w_mix),   .key(key), .out(out));
endmodule

// File: rtl/keyExpansion.sv
// Full AES key schedule. Round key k occupies
// fullkeys[128*(Nr+1)-1-128*k -: 128].
// Ports: key (cipher key, N bits), fullkeys (all Nr+1 round keys).
module keyExpansion
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [N-1:0]           key,
    output logic [128*(Nr+1)-1:0]  fullkeys
);
    localparam int NW = 4*(Nr+1);

    always_comb begin
        logic [31:0] w [NW];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        w        = '{default: '0};
        rcon     = 8'h01;
        tmp      = '0;
        fullkeys = '0;
        for (int i = 0; i < Nk; i++) begin
            w[i] = key[N-1-32*i -: 32];
        end
        for (int i = Nk; i < NW; i++) begin
            tmp = w[i-1];
            if (i % Nk == 0) begin
                tmp  = sub_word(rot_word(tmp)) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-Nk] ^ tmp;
        end
        for (int i = 0; i < NW; i++) begin
            fullkeys[128*(Nr+1)-1-32*i -: 32] = w[i];
        end
    end
endmodule

// File: rtl/mixColumns.sv
// Column mixing: each 32-bit column multiplied by the fixed AES matrix.
// Ports: in (state), out (mixed state).
module mixColumns
    import aes_pkg::*;
(
    input  logic [127:0] in,
    output logic [127:0] out
);
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign out[127-32*c -: 32] = mix_col(in[127-32*c -: 32]);
    end
endmodule

// File: rtl/shiftRows.sv
// Cyclic left shift of row r by r bytes. Bytes are column-major with
// byte 0 in the top bits, so byte index is row + 4*column.
// Ports: in (state), out (shifted state).
module shiftRows (
    input  logic [127:0] in,
    output logic [127:0] out
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign out[127-8*(r+4*c) -: 8] = in[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end
endmodule

// File: rtl/subBytes.sv
// Byte-wise S-box substitution of a 128-bit state.
// Ports: in (state), out (substituted state).
module subBytes
    import aes_pkg::*;
(
    input  logic [127:0] in,
    output logic [127:0] out
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign out[127-8*i -: 8] = sbox(in[127-8*i -: 8]);
    end
endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor, one round per clock, valid/ready on both sides.
// Ports: clk, rst_n (sync active-low), in_valid/in_ready/in/key (block
// source), out_valid/out_ready/out (ciphertext sink), busy (ROUND or DONE).
//
// state | meaning
// IDLE  | waiting for a plaintext/key pair, in_ready high
// ROUND | one transform per edge, r_round selects which
// DONE  | ciphertext held on out until the sink takes it
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in,
    input  logic [N-1:0]  key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out,
    output logic          busy
);
    localparam int RW = $clog2(Nr+1);
    localparam int KW = 128*(Nr+1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(Nr);

    if (!legal_params(N, Nk, Nr)) begin : g_bad_params
        $error("aes_encrypt_iter: (N, Nk, Nr) must be (128,4,10), (192,6,12) or (256,8,14)");
    end

    aes_state_e    r_state, w_next_state;
    logic [RW-1:0] r_round;
    logic [127:0]  r_data;
    logic [127:0]  r_out;
    logic [N-1:0]  r_key;
    logic [KW-1:0] w_fullkeys;
    logic [127:0]  w_round_key;
    logic [127:0]  w_step;

    keyExpansion #(.N(N), .Nk(Nk), .Nr(Nr)) u_key_exp (
        .key      (r_key),
        .fullkeys (w_fullkeys)
    );

    assign w_round_key = w_fullkeys[KW-1-128*int'(r_round) -: 128];

    aes_round_step #(.Nr(Nr), .RW(RW)) u_step (
        .i_state     (r_data),
        .i_round_key (w_round_key),
        .i_round     (r_round),
        .o_state     (w_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_round <= '0;
            r_data  <= '0;
            r_key   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in;
                        r_key   <= key;
                        r_round <= '0;
                    end
                end
                ROUND: begin
                    r_data <= w_step;
                    // out is only written by the final round, so it keeps the
                    // previous ciphertext while the next block is in flight
                    if (r_round == LAST_ROUND) begin
                        r_out <= w_step;
                    end else begin
                        r_round <= r_round + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (r_round == LAST_ROUND) w_next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign out = r_out;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
module tb_aes_encrypt_iter;
    import aes_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [127:0]      pt;
    logic [255:0]      key;
    logic [2:0]        iv;
    logic [2:0]        ir;
    logic [2:0]        ov;
    logic [2:0]        bz;
    logic              out_ready;
    logic [2:0][127:0] ot;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] sb [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_encrypt_iter #(.N(128), .Nr(10), .Nk(4)) dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in(pt), .key(key[255:128]), .out_valid(ov[0]), .out_ready(out_ready),
        .out(ot[0]), .busy(bz[0]));

    aes_encrypt_iter #(.N(192), .Nr(12), .Nk(6)) dut192 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in(pt), .key(key[255:64]), .out_valid(ov[1]), .out_ready(out_ready),
        .out(ot[1]), .busy(bz[1]));

    aes_encrypt_iter #(.N(256), .Nr(14), .Nk(8)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in(pt), .key(key), .out_valid(ov[2]), .out_ready(out_ready),
        .out(ot[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: GF(2^8) arithmetic on byte arrays
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_gf(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = 8'h63;
        for (int k = 0; k < 5; k++) s ^= (inv << k) | (inv >> (8 - k));
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [255:0] k,
                                             input int nk);
        int          nr;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] res;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
        for (int rnd = 0; rnd <= nr; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
                s = t;
                if (rnd < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] ^= w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers (called #1 after a rising edge)
    task automatic do_block(input int s, input logic [127:0] p, input logic [255:0] k,
                            input logic [127:0] exp, input int stall, input string tag);
        int lat;
        int nr;
        nr = (s == 0) ? 10 : (s == 1) ? 12 : 14;
        chk({tag, "_rdy"}, ir[s], 1);
        pt = p; key = k; iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        pt = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!ov[s] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, nr + 1);
        chk({tag, "_ct"}, ot[s], exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {ov[s], ir[s], ot[s]}, {1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_hs"}, {ov[s], ir[s], bz[s]}, 3'b010);
        @(posedge clk); #1;
        chk({tag, "_keep"}, {ov[s], ot[s]}, {1'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_q [$];
        int          n_res;
        int          n;
        int          s;
        logic [127:0] p;
        logic [255:0] k;

        for (int x = 0; x < 256; x++) sb[x] = sbox_gf(8'(x));

        rst_n = 1'b0; iv = '0; out_ready = 1'b0; pt = '0; key = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_%0d", i), {ir[i], ov[i], bz[i], ot[i]}, {3'b100, 128'h0});

        // known-answer vectors
        do_block(0, KAT_B_IN, {KAT_B_KEY, 128'h0},    KAT_B_OUT,    0, "b128");
        do_block(1, KAT_C_IN, {KAT_C192_KEY, 64'h0},  KAT_C192_OUT, 0, "c192");
        do_block(2, KAT_C_IN, KAT_C256_KEY,           KAT_C256_OUT, 0, "c256");
        do_block(0, KAT_C_IN, {KAT_C128_KEY, 128'h0}, KAT_C128_OUT, 0, "c128");

        // backpressure: out_ready low for 20 cycles after out_valid
        do_block(0, KAT_B_IN, {KAT_B_KEY, 128'h0}, KAT_B_OUT, 20, "bp");

        // back-to-back with in_valid and out_ready tied high; in/key
        // scrambled whenever the core is not accepting
        iv[0] = 1'b1; out_ready = 1'b1; n_res = 0;
        for (int c = 0; c < 70; c++) begin
            if (ir[0]) begin
                acc_q.push_back(c);
                pt = KAT_C_IN; key = {KAT_C128_KEY, 128'h0};
            end else begin
                pt  = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
            end
            if (ov[0]) begin
                n_res++;
                chk("b2b_ct", ot[0], KAT_C128_OUT);
            end
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        chk("b2b_accepts", acc_q.size(), 6);
        chk("b2b_results", n_res, 5);
        for (int i = 1; i < acc_q.size(); i++)
            chk("b2b_interval", acc_q[i] - acc_q[i-1], 13);
        n = 0;
        while (!ir[0] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("b2b_drain", ir[0], 1);

        // reset in the middle of ROUND at r=5
        pt = KAT_B_IN; key = {KAT_B_KEY, 128'h0}; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", {bz[0], ov[0]}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_reset", {ov[0], bz[0], ir[0], ot[0]}, {3'b001, 128'h0});
        do_block(0, KAT_B_IN, {KAT_B_KEY, 128'h0}, KAT_B_OUT, 0, "after_rst");

        // random blocks against the reference model
        for (int it = 0; it < 24; it++) begin
            s = it % 3;
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            do_block(s, p, k, aes_ref(p, k, 4 + 2*s), int'($urandom_range(0, 3)),
                     $sformatf("rnd%0d_aes%0d", it, 128 + 64*s));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
